// File: rtl/fxp_mul_pipe.sv
// Pipelined signed fixed-point multiplier with optional half-up rounding and saturation.
// Define FXP_MUL_PIPE_INPUT_REG_EN to add an input register stage (latency 3 instead of 2).
module fxp_mul_pipe #(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIIA+WIFA-1:0]   ina,
  input  logic [WIIB+WIFB-1:0]   inb,
  output logic [WOI+WOF-1:0]     out,
  output logic                   overflow
);

  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int PF = WIFA + WIFB;
  localparam int PW = WA + WB;
  localparam int OW = WOI + WOF;
  localparam int SH = (WOF >= PF) ? (WOF - PF) : 0;
  // One spare MSB beyond both the aligned product and the output keeps the
  // rounding carry and the saturation sign check unambiguous.
  localparam int AW = (((PW + SH) > OW) ? (PW + SH) : OW) + 1;

  logic [WA-1:0] a_s;
  logic [WB-1:0] b_s;

`ifdef FXP_MUL_PIPE_INPUT_REG_EN
  logic [WA-1:0] a_reg;
  logic [WB-1:0] b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      a_reg <= ina;
      b_reg <= inb;
    end
  end

  assign a_s = a_reg;
  assign b_s = b_reg;
`else
  assign a_s = ina;
  assign b_s = inb;
`endif

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod_next;
  logic signed [PW-1:0] prod_reg;

  // Both operands sign-extended to full product width, so -max * -max cannot wrap.
  assign a_ext     = PW'($signed(a_s));
  assign b_ext     = PW'($signed(b_s));
  assign prod_next = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
    end else begin
      prod_reg <= prod_next;
    end
  end

  logic signed [AW-1:0] al;

  generate
    if (WOF >= PF) begin : g_extend
      assign al = AW'(prod_reg) <<< SH;
    end else begin : g_drop
      localparam int DR = PF - WOF;
      logic          rnd_bit;
      logic [DR-1:0] dropped_unused;

      assign dropped_unused = prod_reg[DR-1:0];
      assign rnd_bit        = (ROUND != 0) ? prod_reg[DR-1] : 1'b0;
      assign al = AW'($signed(prod_reg[PW-1:DR])) + {{(AW-1){1'b0}}, rnd_bit};
    end
  endgenerate

  logic [AW-OW:0] top_bits;
  logic           fits;
  logic [OW-1:0]  out_next;
  logic           overflow_next;

  // Value fits when every bit from the output sign position upward agrees.
  assign top_bits = al[AW-1:OW-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_comb begin
    out_next      = al[OW-1:0];
    overflow_next = 1'b0;
    if (!fits) begin
      overflow_next = 1'b1;
      out_next      = al[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      out      <= out_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Directed and streaming checks for fxp_mul_pipe at Q8.8 x Q8.8 -> Q12.6,
// one instance rounding and one truncating, driven from the same inputs.
module tb_fxp_mul_pipe;

`ifdef FXP_MUL_PIPE_INPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ina = '0;
  logic [15:0] inb = '0;
  logic [17:0] out_r;
  logic        ovf_r;
  logic [17:0] out_t;
  logic        ovf_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fxp_mul_pipe #(
    .WIIA(8), .WIFA(8), .WIIB(8), .WIFB(8), .WOI(12), .WOF(6), .ROUND(1)
  ) dut (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .out(out_r), .overflow(ovf_r)
  );

  fxp_mul_pipe #(
    .WIIA(8), .WIFA(8), .WIIB(8), .WIFB(8), .WOI(12), .WOF(6), .ROUND(0)
  ) dut_t (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .out(out_t), .overflow(ovf_t)
  );

  // Reference: exact product in Q.16, shift to Q.6 (with +half when rounding), clamp.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit rnd);
    longint p;
    longint r;
    logic [17:0] o;
    logic v;
    p = longint'($signed(a)) * longint'($signed(b));
    r = rnd ? ((p + 512) >>> 10) : (p >>> 10);
    if (r > 131071) begin
      o = 18'h1FFFF;
      v = 1'b1;
    end else if (r < -131072) begin
      o = 18'h20000;
      v = 1'b1;
    end else begin
      o = r[17:0];
      v = 1'b0;
    end
    return {v, o};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ina = 16'h7FFF;
    inb = 16'h7FFF;
    repeat (4) @(negedge clk);
    total++;
    if (out_r !== 18'h0 || ovf_r !== 1'b0) begin
      bad++;
      $display("FAIL reset_round out=%h ovf=%b want out=00000 ovf=0", out_r, ovf_r);
    end
    total++;
    if (out_t !== 18'h0 || ovf_t !== 1'b0) begin
      bad++;
      $display("FAIL reset_trunc out=%h ovf=%b want out=00000 ovf=0", out_t, ovf_t);
    end
    $display("reset: out_r=%h ovf_r=%b out_t=%h ovf_t=%b", out_r, ovf_r, out_t, ovf_t);
  endtask

  task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [17:0] exp_r, input logic exp_vr,
                       input logic [17:0] exp_t, input logic exp_vt);
    @(negedge clk);
    rst = 1'b0;
    ina = a;
    inb = b;
    repeat (LAT) @(negedge clk);
    total++;
    if (out_r !== exp_r || ovf_r !== exp_vr) begin
      bad++;
      $display("FAIL %s_round out=%h ovf=%b want out=%h ovf=%b", name, out_r, ovf_r,
               exp_r, exp_vr);
    end
    total++;
    if (out_t !== exp_t || ovf_t !== exp_vt) begin
      bad++;
      $display("FAIL %s_trunc out=%h ovf=%b want out=%h ovf=%b", name, out_t, ovf_t,
               exp_t, exp_vt);
    end
    $display("%s: a=%h b=%h out_r=%h ovf_r=%b out_t=%h ovf_t=%b", name, a, b, out_r,
             ovf_r, out_t, ovf_t);
  endtask

  task automatic test_basic();
    apply("one_x_two",   16'h0100, 16'h0200, 18'h00080, 1'b0, 18'h00080, 1'b0);
    apply("neg_mixed",   16'h0300, 16'hFE80, 18'h3FEE0, 1'b0, 18'h3FEE0, 1'b0);
  endtask

  task automatic test_saturation();
    apply("sat_pos",     16'h7FFF, 16'h7FFF, 18'h1FFFF, 1'b1, 18'h1FFFF, 1'b1);
    apply("sat_neg",     16'h8000, 16'h7FFF, 18'h20000, 1'b1, 18'h20000, 1'b1);
    apply("minxmin",     16'h8000, 16'h8000, 18'h1FFFF, 1'b1, 18'h1FFFF, 1'b1);
    apply("exact_min",   16'h8000, 16'h1000, 18'h20000, 1'b0, 18'h20000, 1'b0);
  endtask

  task automatic test_rounding();
    apply("half_pos",    16'h0001, 16'h0200, 18'h00001, 1'b0, 18'h00000, 1'b0);
    apply("half_neg",    16'hFFFF, 16'h0200, 18'h00000, 1'b0, 18'h3FFFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [18:0] hist_r [LAT];
    logic [18:0] hist_t [LAT];
    logic [15:0] a;
    logic [15:0] b;
    bit          r;
    // Start from a clean, reset pipeline so every history slot is a known zero.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < LAT; k++) begin
      hist_r[k] = '0;
      hist_t[k] = '0;
    end
    for (int i = 0; i < 10 + LAT + 2; i++) begin
      if (i > 0) begin
        total++;
        if ({ovf_r, out_r} !== hist_r[LAT-1]) begin
          bad++;
          $display("FAIL stream_round[%0d] out=%h ovf=%b want out=%h ovf=%b", i, out_r,
                   ovf_r, hist_r[LAT-1][17:0], hist_r[LAT-1][18]);
        end
        total++;
        if ({ovf_t, out_t} !== hist_t[LAT-1]) begin
          bad++;
          $display("FAIL stream_trunc[%0d] out=%h ovf=%b want out=%h ovf=%b", i, out_t,
                   ovf_t, hist_t[LAT-1][17:0], hist_t[LAT-1][18]);
        end
        $display("stream[%0d]: out_r=%h ovf_r=%b out_t=%h ovf_t=%b", i, out_r, ovf_r,
                 out_t, ovf_t);
      end
      a = 16'($urandom);
      b = 16'($urandom);
      r = (i == 6);
      rst = r;
      ina = a;
      inb = b;
      for (int k = LAT - 1; k > 0; k--) begin
        hist_r[k] = hist_r[k-1];
        hist_t[k] = hist_t[k-1];
      end
      hist_r[0] = model(a, b, 1'b1);
      hist_t[0] = model(a, b, 1'b0);
      if (r) begin
        for (int k = 0; k < LAT; k++) begin
          hist_r[k] = '0;
          hist_t[k] = '0;
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
